mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port round-robin arbiter sharing the single-port negedge-clocked exmem RAM between the MIPS core (port 0) and a loader/debug master (port 1).
- Sits between the requesters and the RAM, and drives the RAM's en/memwrite/adr/writedata.
- One access per cycle maximum, with one access in flight.
- Read data is captured from the RAM and returned with a one-cycle ack pulse.

Parameters:
- WIDTH, 8, data width; matches the RAM word width.
- RAM_ADDR_BITS, 8, address width.

Ports:
- clk  input  1  system clock; all arbiter state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- p0_req  input  1  port 0 request; held with its fields until p0_ack.
- p0_we  input  1  port 0 write (1) / read (0).
- p0_adr  input  RAM_ADDR_BITS  port 0 address.
- p0_wd  input  WIDTH  port 0 write data.
- p0_ack  output  1  one-cycle completion pulse for port 0.
- p0_rd  output  WIDTH  port 0 read data; valid while p0_ack=1, then held.
- p1_req, p1_we, p1_adr, p1_wd, p1_ack, p1_rd: same as port 0, for port 1.
- mem_en  output  1  to RAM en.
- mem_we  output  1  to RAM memwrite.
- mem_adr  output  RAM_ADDR_BITS  to RAM adr.
- mem_wd  output  WIDTH  to RAM writedata.
- mem_rd  input  WIDTH  from RAM memdata; updated at the negedge following launch.

Behaviour:
- State: busy flag; owner (0/1) of the in-flight access; prio (port favoured on a tie).
- Reset values: all outputs 0; busy=0; owner=0; prio=0.
- Launch at posedge k:
  - Eligible ports are those with req=1, excluding the in-flight owner when busy=1. This masking prevents a requester's stale req from being re-granted on its ack edge.
  - If any port is eligible, the winner is the single eligible port, or prio if both are eligible.
  - mem_en=1, mem_we/mem_adr/mem_wd registered from the winner, owner=winner, busy=1, prio=other port.
- RAM timing: the RAM acts on the negedge inside cycle k. mem_rd is valid before posedge k+1.
- Completion at posedge k+1:
  - owner's xN_rd <= mem_rd (also on writes; RAM returns pre-write data, which the requester ignores).
  - owner's xN_ack=1 for exactly one cycle.
- Same edge as completion:
  - If the other port is eligible, launch it; busy stays 1.
  - Otherwise mem_en=0 and busy=0.
- Latency and throughput:
  - Latency from the edge where req is sampled with the port idle to the ack edge: 1 cycle.
  - Sustained throughput: 1 access/cycle when both ports request (alternating).
  - A single port requesting back-to-back gets 1 access per 2 cycles (masking).
- Address/data pass through unchanged; no width conversion or wrap logic. Address range is the full 2**RAM_ADDR_BITS.
- Only one xN_ack is high in any cycle.
- Reset mid-operation:
  - An access launched at the edge before reset has already executed at its negedge, so a write has taken effect.
  - No ack is issued for it, and mem_en is 0 from the reset edge.
- req deasserted while not yet granted: the request is dropped; no ack.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1 bit) and outputs p0_grants, p1_grants (16 bits each).
  - Each counter increments on its port's launch edge and saturates at 16'hFFFF.
  - stats_clr=1 or reset zeroes both counters; clear wins over a same-cycle increment.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single read: RAM[0x10]=0xA5; p0 read of 0x10 sampled at edge 1 -> mem_en=1, mem_adr=0x10 after edge 1; p0_ack=1 and p0_rd=0xA5 after edge 2; mem_en=0 after edge 2.
- Write then read: p1 writes 0x3C to 0x20 (ack), then reads 0x20 -> p1_rd=0x3C; p0_ack never asserts.
- Contention after reset: p0 and p1 request at the same edge -> p0 launched first (prio=0); p1 launched on the p0 ack edge; acks on consecutive cycles p0 then p1; mem_en held high for 2 cycles.
- Single-port streaming: p0_req held high for 4 transactions, p1 idle -> mem_en pattern 1,0,1,0…; p0_ack every other cycle; no duplicate access on any ack edge.
- Reset mid-operation: p1 write of 0x77 to 0x05 launched, reset asserted at the next edge -> RAM[0x05]=0x77, p1_ack stays 0, all outputs 0 after the reset edge.
- MEM_ARB_STATS_EN: 3 p0 grants and 2 p1 grants -> p0_grants=3, p1_grants=2; then stats_clr=1 for one cycle -> both 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port negedge RAM.
// Optional grant counters are enabled with `define MEM_ARB_STATS_EN.

// Per-port completion path: turns "my access is finishing" into the ack
// pulse and captures the RAM read data.
module mem_arb_port #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_done,
  input  logic [WIDTH-1:0] i_mem_rd,
  output logic             o_ack,
  output logic [WIDTH-1:0] o_rd
);
  logic             r_ack;
  logic [WIDTH-1:0] r_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_rd  <= '0;
    end else begin
      r_ack <= i_done;
      if (i_done) r_rd <= i_mem_rd;
    end
  end

  assign o_ack = r_ack;
  assign o_rd  = r_rd;
endmodule

module mem_arbiter #(
  parameter int WIDTH         = 8,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [RAM_ADDR_BITS-1:0] p0_adr,
  input  logic [WIDTH-1:0]         p0_wd,
  output logic                     p0_ack,
  output logic [WIDTH-1:0]         p0_rd,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [RAM_ADDR_BITS-1:0] p1_adr,
  input  logic [WIDTH-1:0]         p1_wd,
  output logic                     p1_ack,
  output logic [WIDTH-1:0]         p1_rd,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_wd,
  input  logic [WIDTH-1:0]         mem_rd
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [15:0]              p0_grants,
  output logic [15:0]              p1_grants
`endif
);
  localparam int NP = 2;

  logic [NP-1:0]                    w_req, w_we, w_done, w_elig, w_ack;
  logic [NP-1:0][RAM_ADDR_BITS-1:0] w_adr;
  logic [NP-1:0][WIDTH-1:0]         w_wd, w_rd;
  logic                             w_win, w_launch;

  logic                     r_busy, r_owner, r_prio;
  logic                     r_en, r_we;
  logic [RAM_ADDR_BITS-1:0] r_adr;
  logic [WIDTH-1:0]         r_wd;

  assign w_req = {p1_req, p0_req};
  assign w_we  = {p1_we,  p0_we};
  assign w_adr = {p1_adr, p0_adr};
  assign w_wd  = {p1_wd,  p0_wd};

  // The finishing owner is masked so its still-high req is not re-granted
  // on the very edge that acks it.
  for (genvar g = 0; g < NP; g++) begin : g_port
    assign w_done[g] = r_busy & (r_owner == 1'(g));
    assign w_elig[g] = w_req[g] & ~w_done[g];

    mem_arb_port #(.WIDTH(WIDTH)) u_port (
      .clk      (clk),
      .reset    (reset),
      .i_done   (w_done[g]),
      .i_mem_rd (mem_rd),
      .o_ack    (w_ack[g]),
      .o_rd     (w_rd[g])
    );
  end

  assign w_launch = |w_elig;
  assign w_win    = (&w_elig) ? r_prio : w_elig[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_en    <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wd    <= '0;
    end else begin
      r_busy <= w_launch;
      r_en   <= w_launch;
      if (w_launch) begin
        r_owner <= w_win;
        r_prio  <= ~w_win;
        r_we    <= w_we[w_win];
        r_adr   <= w_adr[w_win];
        r_wd    <= w_wd[w_win];
      end
    end
  end

  assign mem_en  = r_en;
  assign mem_we  = r_we;
  assign mem_adr = r_adr;
  assign mem_wd  = r_wd;
  assign p0_ack  = w_ack[0];
  assign p1_ack  = w_ack[1];
  assign p0_rd   = w_rd[0];
  assign p1_rd   = w_rd[1];

`ifdef MEM_ARB_STATS_EN
  logic [NP-1:0][15:0] r_grants;

  // Clear has priority over a same-edge grant; counters stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (reset || stats_clr)
        r_grants[i] <= '0;
      else if (w_launch && (w_win == 1'(i)) && (r_grants[i] != 16'hFFFF))
        r_grants[i] <= r_grants[i] + 16'd1;
    end
  end

  assign p0_grants = r_grants[0];
  assign p1_grants = r_grants[1];
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: negedge RAM model, transaction-level
// reference model, per-cycle compare plus directed literal checks.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [7:0] p0_adr = 0, p0_wd = 0, p1_adr = 0, p1_wd = 0;
  logic       p0_ack, p1_ack, mem_en, mem_we;
  logic [7:0] p0_rd, p1_rd, mem_adr, mem_wd, mem_rd;
  logic       stats_clr = 0;
  logic [15:0] p0_grants, p1_grants;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(8), .RAM_ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wd(p0_wd),
    .p0_ack(p0_ack), .p0_rd(p0_rd),
    .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wd(p1_wd),
    .p1_ack(p1_ack), .p1_rd(p1_rd),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
`ifdef MEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .p0_grants(p0_grants), .p1_grants(p1_grants)
`endif
  );

`ifndef MEM_ARB_STATS_EN
  assign p0_grants = 16'h0;
  assign p1_grants = 16'h0;
`endif

  function automatic logic [7:0] init_val(input int i);
    if (i == 16) return 8'hA5;
    return 8'((i * 37 + 11) ^ 8'h5A);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Negedge single-port RAM: read returns the pre-write contents.
  logic [7:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_val(i);
    mem_rd = 8'h0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        mem_rd <= ram[mem_adr];
        if (mem_we) ram[mem_adr] = mem_wd;
      end
    end
  end

  // Reference model: which port is in flight, who is favoured, and a shadow
  // memory that supplies the read data the in-flight access must return.
  logic [7:0] shadow [256];
  logic       e_en, e_we, e_ack0, e_ack1;
  logic [7:0] e_adr, e_wd, e_rd0, e_rd1, pend_rd;
  int         infl, fav, g0, g1;
  initial begin
    int done, win;
    logic w;
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    infl = -1; fav = 0; g0 = 0; g1 = 0; pend_rd = 0;
    {e_en, e_we, e_ack0, e_ack1} = '0;
    {e_adr, e_wd, e_rd0, e_rd1} = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        {e_en, e_we, e_ack0, e_ack1} = '0;
        {e_adr, e_wd, e_rd0, e_rd1} = '0;
        infl = -1; fav = 0; g0 = 0; g1 = 0;
      end else begin
        done = infl;
        e_ack0 = (done == 0);
        e_ack1 = (done == 1);
        if (done == 0) e_rd0 = pend_rd;
        if (done == 1) e_rd1 = pend_rd;
        if (p0_req && done != 0 && p1_req && done != 1) win = fav;
        else if (p0_req && done != 0) win = 0;
        else if (p1_req && done != 1) win = 1;
        else win = -1;
        if (stats_clr) begin g0 = 0; g1 = 0; end
        if (win >= 0) begin
          w = (win == 0) ? p0_we : p1_we;
          a = (win == 0) ? p0_adr : p1_adr;
          d = (win == 0) ? p0_wd : p1_wd;
          e_en = 1; e_we = w; e_adr = a; e_wd = d;
          pend_rd = shadow[a];
          if (w) shadow[a] = d;
          infl = win;
          fav = 1 - win;
          if (!stats_clr) begin
            if (win == 0 && g0 < 65535) g0++;
            if (win == 1 && g1 < 65535) g1++;
          end
        end else begin
          e_en = 0;
          infl = -1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk); #1;
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("p0_ack", 32'(p0_ack), 32'(e_ack0));
      chk("p1_ack", 32'(p1_ack), 32'(e_ack1));
      chk("p0_rd", 32'(p0_rd), 32'(e_rd0));
      chk("p1_rd", 32'(p1_rd), 32'(e_rd1));
      if (e_en) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_adr", 32'(mem_adr), 32'(e_adr));
        chk("mem_wd", 32'(mem_wd), 32'(e_wd));
      end
`ifdef MEM_ARB_STATS_EN
      chk("p0_grants", 32'(p0_grants), 32'(g0));
      chk("p1_grants", 32'(p1_grants), 32'(g1));
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    p0_req = 0; p1_req = 0; stats_clr = 0; reset = 1;
    step(); step();
    chk("reset_state", 32'({mem_en, mem_we, p0_ack, p1_ack, mem_adr, mem_wd, p0_rd, p1_rd} != 0), 32'd0);
    reset = 0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin p0_we = w; p0_adr = a; p0_wd = d; p0_req = 1; end
    else        begin p1_we = w; p1_adr = a; p1_wd = d; p1_req = 1; end
  endtask

  task automatic xact(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
    bit got = 0;
    set_req(p, w, a, d);
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if ((p == 0) ? p0_ack : p1_ack) got = 1;
    end
    chk("xact_ack", 32'(got), 32'd1);
    if (p == 0) p0_req = 0; else p1_req = 0;
  endtask

  task automatic rnd_port(input int p);
    logic rq, ak;
    rq = (p == 0) ? p0_req : p1_req;
    ak = (p == 0) ? p0_ack : p1_ack;
    if (rq) begin
      if (ak) begin
        if ($urandom % 2 == 0) set_req(p, 1'($urandom), 8'($urandom), 8'($urandom));
        else if (p == 0) p0_req = 0; else p1_req = 0;
      end
    end else if ($urandom % 3 == 0) begin
      set_req(p, 1'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    logic [7:0] en_pat, ack_pat;
    int mism;
    do_reset();

    // Single read
    set_req(0, 0, 8'h10, 8'h00);
    step();
    chk("rd1_en", 32'(mem_en), 32'd1);
    chk("rd1_adr", 32'(mem_adr), 32'h10);
    step();
    chk("rd1_ack", 32'(p0_ack), 32'd1);
    chk("rd1_data", 32'(p0_rd), 32'hA5);
    chk("rd1_en_off", 32'(mem_en), 32'd0);
    p0_req = 0;
    do_reset();

    // Write then read on port 1
    xact(1, 1, 8'h20, 8'h3C);
    xact(1, 0, 8'h20, 8'h00);
    chk("wr_rd_data", 32'(p1_rd), 32'h3C);
    do_reset();

    // Contention after reset: p0 first, p1 on p0's ack edge
    set_req(0, 0, 8'h30, 8'h00);
    set_req(1, 0, 8'h31, 8'h00);
    step();
    chk("ct_en1", 32'(mem_en), 32'd1);
    chk("ct_adr1", 32'(mem_adr), 32'h30);
    step();
    chk("ct_acks1", 32'({p0_ack, p1_ack}), 32'b10);
    chk("ct_en2", 32'(mem_en), 32'd1);
    chk("ct_adr2", 32'(mem_adr), 32'h31);
    p0_req = 0;
    step();
    chk("ct_acks2", 32'({p0_ack, p1_ack}), 32'b01);
    chk("ct_en3", 32'(mem_en), 32'd0);
    p1_req = 0;
    do_reset();

    // Loser withdraws before being granted: no ack for it
    set_req(0, 0, 8'h40, 8'h00);
    set_req(1, 1, 8'h41, 8'hEE);
    step();
    p1_req = 0;
    step();
    chk("drop_en", 32'(mem_en), 32'd0);
    p0_req = 0;
    step();
    chk("drop_p1_ack", 32'(p1_ack), 32'd0);
    do_reset();

    // Single-port streaming
    set_req(0, 0, 8'h50, 8'h00);
    en_pat = 0; ack_pat = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      en_pat = {en_pat[6:0], mem_en};
      ack_pat = {ack_pat[6:0], p0_ack};
      if (p0_ack) p0_adr = p0_adr + 8'd1;
    end
    chk("stream_en", 32'(en_pat), 32'hAA);
    chk("stream_ack", 32'(ack_pat), 32'h55);
    p0_req = 0;
    step();

    // Reset during an in-flight write
    set_req(1, 1, 8'h05, 8'h77);
    step();
    chk("rmid_en", 32'(mem_en), 32'd1);
    reset = 1;
    step();
    chk("rmid_ack", 32'(p1_ack), 32'd0);
    chk("rmid_out", 32'({mem_en, p0_ack, p1_ack, mem_adr, mem_wd, p0_rd, p1_rd} != 0), 32'd0);
    chk("rmid_ram", 32'(ram[5]), 32'h77);
    p1_req = 0;
    reset = 0;

`ifdef MEM_ARB_STATS_EN
    do_reset();
    xact(0, 0, 8'h60, 8'h00);
    xact(1, 0, 8'h61, 8'h00);
    xact(0, 0, 8'h62, 8'h00);
    xact(1, 0, 8'h63, 8'h00);
    xact(0, 0, 8'h64, 8'h00);
    step();
    chk("stats_p0", 32'(p0_grants), 32'd3);
    chk("stats_p1", 32'(p1_grants), 32'd2);
    stats_clr = 1;
    step();
    stats_clr = 0;
    chk("stats_clr", 32'({p0_grants, p1_grants}), 32'd0);
`endif

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      rnd_port(0);
      rnd_port(1);
    end
    p0_req = 0; p1_req = 0;
    step(); step(); step();

    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i]) mism++;
    chk("ram_final", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
